adj_button_scheduler: RTL and testbench

ADJ_BUTTON_SCHEDULER -- requirements
Module: adj_button_scheduler

---
 rtl/fun_vga_pkg.sv | 57 +++++
 rtl/btn_debounce.sv | 55 +++++
 rtl/adj_button_scheduler.sv | 136 +++++++++++++
 tb/tb_adj_button_scheduler.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fun_vga_pkg.sv
// Shared definitions for the adjust-button scheduler: FSM state encoding,
// active_sel encodings, parameter defaults and small grant/decode helpers.
package fun_vga_pkg;

    // Parameter defaults (all legal in 1..63)
    localparam int DEF_DEBOUNCE_FRAMES = 3;
    localparam int DEF_REPEAT_DELAY    = 30;
    localparam int DEF_REPEAT_RATE     = 6;

    // Width of every frame counter in this block
    localparam int CNT_W = 6;

    // Scheduler states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DELAY    = 2'd1,
        ST_REPEAT   = 2'd2,
        ST_WAIT_REL = 2'd3
    } sched_state_e;

    // active_sel encodings
    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_HRS  = 2'd1;
    localparam logic [1:0] SEL_MIN  = 2'd2;
    localparam logic [1:0] SEL_SEC  = 2'd3;

    // Fixed-priority grant: hrs > min > sec. lvl is {sec, min, hrs}.
    function automatic logic [1:0] grant_sel(input logic [2:0] lvl);
        logic [1:0] sel;
        sel = SEL_NONE;
        if (lvl[0])
            sel = SEL_HRS;
        else if (lvl[1])
            sel = SEL_MIN;
        else if (lvl[2])
            sel = SEL_SEC;
        return sel;
    endfunction

    // Decode a selection into a {sec, min, hrs} one-hot pulse vector
    function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        case (sel)
            SEL_HRS: oh = 3'b001;
            SEL_MIN: oh = 3'b010;
            SEL_SEC: oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Debounced level of the currently selected button
    function automatic logic sel_level(input logic [1:0] sel, input logic [2:0] lvl);
        return |(sel_onehot(sel) & lvl);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a frame-tick debouncer for one raw
// button. The debounced level flips only after DEBOUNCE_FRAMES consecutive
// frame ticks on which the synchronized level disagreed with it.
module btn_debounce
    import fun_vga_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_tick,
    input  logic btn_raw,
    output logic level
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_FRAMES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] run_cnt;
    logic             level_q;

    // Bring the asynchronous button into the clk domain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Count consecutive disagreeing ticks; any agreeing tick restarts the run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
            level_q <= 1'b0;
        end else if (frame_tick) begin
            if (sync_p1 != level_q) begin
                if (run_cnt == LAST_CNT) begin
                    level_q <= sync_p1;
                    run_cnt <= '0;
                end else begin
                    run_cnt <= run_cnt + 6'd1;
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/adj_button_scheduler.sv
// Adjust-button scheduler: debounces the hrs/min/sec buttons, grants one of
// them by fixed priority and issues a single adjust pulse on grant, then
// auto-repeat pulses after REPEAT_DELAY ticks and every REPEAT_RATE ticks
// while the granted button stays held. After the granted button is released
// the scheduler waits until all buttons are released before re-arming.
module adj_button_scheduler
    import fun_vga_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = DEF_DEBOUNCE_FRAMES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_hrs,
    input  logic       btn_min,
    input  logic       btn_sec,
    output logic       adj_hrs,
    output logic       adj_min,
    output logic       adj_sec,
    output logic [1:0] active_sel,
    output logic       busy
);

    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE);

    // Debounced levels, packed as {sec, min, hrs}
    logic [2:0]       lvl;

    sched_state_e     state_q;
    sched_state_e     state_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [1:0]       sel_q;
    logic [1:0]       sel_nxt;
    logic             fire;
    logic [2:0]       adj_q;
    logic [2:0]       adj_nxt;

    btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb_hrs (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn_raw    (btn_hrs),
        .level      (lvl[0])
    );

    btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb_min (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn_raw    (btn_min),
        .level      (lvl[1])
    );

    btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_deb_sec (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn_raw    (btn_sec),
        .level      (lvl[2])
    );

    // State, repeat counter, grant and registered pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= SEL_NONE;
            adj_q   <= 3'b000;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            sel_q   <= sel_nxt;
            adj_q   <= adj_nxt;
        end
    end

    // Next-state decision; nothing moves except on a frame tick. A release
    // seen on the same tick as counter expiry wins, so no pulse is issued.
    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        sel_nxt   = sel_q;
        fire      = 1'b0;
        if (frame_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (|lvl) begin
                        sel_nxt   = grant_sel(lvl);
                        cnt_nxt   = DELAY_LOAD;
                        state_nxt = ST_DELAY;
                        fire      = 1'b1;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (!sel_level(sel_q, lvl)) begin
                        state_nxt = ST_WAIT_REL;
                    end else if (cnt_q == 6'd1) begin
                        cnt_nxt   = RATE_LOAD;
                        state_nxt = ST_REPEAT;
                        fire      = 1'b1;
                    end else if (cnt_q > 6'd1) begin
                        cnt_nxt   = cnt_q - 6'd1;
                    end
                end
                ST_WAIT_REL: begin
                    if (lvl == 3'b000) begin
                        sel_nxt   = SEL_NONE;
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    sel_nxt   = SEL_NONE;
                end
            endcase
        end
    end

    // Pulse decode: only the granted button can ever pulse
    always_comb begin
        adj_nxt = 3'b000;
        if (fire)
            adj_nxt = sel_onehot(sel_nxt);
    end

    assign adj_hrs    = adj_q[0];
    assign adj_min    = adj_q[1];
    assign adj_sec    = adj_q[2];
    assign active_sel = sel_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adj_button_scheduler.sv
// Bench for adj_button_scheduler with default parameters 3/30/6.
module tb_adj_button_scheduler;

    localparam int DF       = 3;
    localparam int RD       = 30;
    localparam int RR       = 6;
    localparam int TICK_GAP = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_tick;
    logic [2:0] btn;          // {sec, min, hrs}
    logic       btn_hrs, btn_min, btn_sec;
    logic       adj_hrs, adj_min, adj_sec;
    logic [1:0] active_sel;
    logic       busy;

    assign btn_hrs = btn[0];
    assign btn_min = btn[1];
    assign btn_sec = btn[2];

    always #5 clk = ~clk;

    adj_button_scheduler #(
        .DEBOUNCE_FRAMES (DF),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .btn_hrs    (btn_hrs),
        .btn_min    (btn_min),
        .btn_sec    (btn_sec),
        .adj_hrs    (adj_hrs),
        .adj_min    (adj_min),
        .adj_sec    (adj_sec),
        .active_sel (active_sel),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;
    int pulses [3];

    // Reference model: synchronizer delay, run-length debounce and an
    // elapsed-ticks scheduler (pulse at RD ticks after grant, then every RR).
    logic [2:0] m_s1, m_s2, m_lvl, m_adj;
    int         m_run [3];
    int         m_grant;   // 0 none, 1 hrs, 2 min, 3 sec
    bit         m_wait;
    int         m_k;

    typedef struct {
        logic [2:0] b;
        int         ticks;
        logic [1:0] sel;
        logic       bsy;
        int         p_hrs;
        int         p_min;
        int         p_sec;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_adj = '0;
        for (int b = 0; b < 3; b++) m_run[b] = 0;
        m_grant = 0; m_wait = 0; m_k = 0;
    endtask

    task automatic model_step();
        logic [2:0] old_lvl;
        logic [2:0] old_s2;
        bit         fire;
        if (!rst_n) begin
            model_reset();
            return;
        end
        old_lvl = m_lvl;
        old_s2  = m_s2;
        fire    = 0;
        if (frame_tick) begin
            for (int b = 0; b < 3; b++) begin
                if (old_s2[b] != m_lvl[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DF) begin
                        m_lvl[b] = old_s2[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            if (m_grant == 0) begin
                if (old_lvl != 3'b000) begin
                    m_grant = old_lvl[0] ? 1 : (old_lvl[1] ? 2 : 3);
                    m_k = 0; m_wait = 0; fire = 1;
                end
            end else if (!m_wait) begin
                if (!old_lvl[m_grant-1]) begin
                    m_wait = 1;
                end else begin
                    m_k++;
                    if (m_k == RD || (m_k > RD && (m_k - RD) % RR == 0)) fire = 1;
                end
            end else if (old_lvl == 3'b000) begin
                m_grant = 0; m_wait = 0;
            end
        end
        m_adj = fire ? 3'(1 << (m_grant - 1)) : 3'b000;
        m_s2 = m_s1;
        m_s1 = btn;
    endtask

    task automatic compare_model();
        logic [2:0] a;
        a = {adj_sec, adj_min, adj_hrs};
        check("model_adj", a, m_adj);
        check("model_sel", active_sel, m_grant);
        check("model_busy", busy, m_grant != 0);
        check("adj_onehot", ($countones(a) <= 1), 1);
    endtask

    // One clock: inputs change on negedge, outputs sampled 1ns after posedge
    task automatic cycle(input logic ft);
        frame_tick = ft;
        @(posedge clk);
        model_step();
        #1;
        compare_model();
        if (adj_hrs === 1'b1) pulses[0]++;
        if (adj_min === 1'b1) pulses[1]++;
        if (adj_sec === 1'b1) pulses[2]++;
        @(negedge clk);
    endtask

    task automatic run_ticks(input logic [2:0] b, input int n);
        btn = b;
        repeat (n) begin
            repeat (TICK_GAP - 1) cycle(1'b0);
            cycle(1'b1);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_adj", {adj_sec, adj_min, adj_hrs}, 0);
        check("rst_sel", active_sel, 0);
        check("rst_busy", busy, 0);
    endtask

    task automatic expect_seg(input string name, input int h0, input int m0, input int s0,
                              input int dh, input int dm, input int ds,
                              input logic [1:0] sel, input logic bsy);
        check({name, "_hrs_pulses"}, pulses[0] - h0, dh);
        check({name, "_min_pulses"}, pulses[1] - m0, dm);
        check({name, "_sec_pulses"}, pulses[2] - s0, ds);
        check({name, "_sel"}, active_sel, sel);
        check({name, "_busy"}, busy, bsy);
    endtask

    initial begin
        int h0, m0, s0;
        rst_n = 1'b0; frame_tick = 1'b0; btn = 3'b000;
        for (int b = 0; b < 3; b++) pulses[b] = 0;
        model_reset();

        tbl.push_back('{3'b000,  5, 2'd0, 1'b0, 0, 0, 0}); // idle
        tbl.push_back('{3'b001,  2, 2'd0, 1'b0, 0, 0, 0}); // glitch too short
        tbl.push_back('{3'b000,  3, 2'd0, 1'b0, 0, 0, 0});
        tbl.push_back('{3'b010,  4, 2'd2, 1'b1, 0, 1, 0}); // grant at tick 4
        tbl.push_back('{3'b010, 30, 2'd2, 1'b1, 0, 1, 0}); // first repeat at 34
        tbl.push_back('{3'b010, 12, 2'd2, 1'b1, 0, 2, 0}); // 40, 46
        tbl.push_back('{3'b000,  3, 2'd2, 1'b1, 0, 0, 0}); // release debouncing
        tbl.push_back('{3'b000,  1, 2'd2, 1'b1, 0, 0, 0}); // WAIT_REL
        tbl.push_back('{3'b000,  1, 2'd0, 1'b0, 0, 0, 0}); // IDLE
        tbl.push_back('{3'b101,  4, 2'd1, 1'b1, 1, 0, 0}); // hrs beats sec
        tbl.push_back('{3'b100,  4, 2'd1, 1'b1, 0, 0, 0}); // hrs released
        tbl.push_back('{3'b100, 10, 2'd1, 1'b1, 0, 0, 0}); // sec held: no pulse
        tbl.push_back('{3'b000,  4, 2'd0, 1'b0, 0, 0, 0}); // all released
        tbl.push_back('{3'b100,  4, 2'd3, 1'b1, 0, 0, 1}); // sec re-pressed
        tbl.push_back('{3'b100, 26, 2'd3, 1'b1, 0, 0, 0});
        tbl.push_back('{3'b000,  4, 2'd3, 1'b1, 0, 0, 0}); // release beats expiry
        tbl.push_back('{3'b000,  1, 2'd0, 1'b0, 0, 0, 0});

        @(negedge clk);
        apply_reset();
        repeat (3) cycle(1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            h0 = pulses[0]; m0 = pulses[1]; s0 = pulses[2];
            run_ticks(tbl[i].b, tbl[i].ticks);
            expect_seg($sformatf("vec%0d", i), h0, m0, s0,
                       tbl[i].p_hrs, tbl[i].p_min, tbl[i].p_sec, tbl[i].sel, tbl[i].bsy);
        end

        // Frame ticks stall mid-REPEAT, then resume from the held count
        h0 = pulses[0]; m0 = pulses[1]; s0 = pulses[2];
        run_ticks(3'b010, 36);
        expect_seg("stall_pre", h0, m0, s0, 0, 2, 0, 2'd2, 1'b1);
        m0 = pulses[1];
        repeat (1000) cycle(1'b0);
        expect_seg("stall_hold", h0, m0, s0, 0, 0, 0, 2'd2, 1'b1);
        run_ticks(3'b010, 3);
        expect_seg("stall_resume3", h0, m0, s0, 0, 0, 0, 2'd2, 1'b1);
        run_ticks(3'b010, 1);
        expect_seg("stall_resume4", h0, m0, s0, 0, 1, 0, 2'd2, 1'b1);
        m0 = pulses[1];
        run_ticks(3'b000, 5);
        expect_seg("stall_idle", h0, m0, s0, 0, 0, 0, 2'd0, 1'b0);

        // Back-to-back frame ticks count individually
        btn = 3'b100;
        repeat (3) cycle(1'b0);
        repeat (4) cycle(1'b1);
        expect_seg("burst_grant", h0, m0, s0, 0, 0, 1, 2'd3, 1'b1);
        s0 = pulses[2];
        repeat (29) cycle(1'b1);
        expect_seg("burst_delay", h0, m0, s0, 0, 0, 0, 2'd3, 1'b1);
        cycle(1'b1);
        expect_seg("burst_repeat", h0, m0, s0, 0, 0, 1, 2'd3, 1'b1);
        s0 = pulses[2];
        btn = 3'b000;
        repeat (3) cycle(1'b0);
        repeat (5) cycle(1'b1);
        expect_seg("burst_idle", h0, m0, s0, 0, 0, 0, 2'd0, 1'b0);

        // Reset at tick 20 of a hold, released at tick 22 with button held
        run_ticks(3'b010, 20);
        expect_seg("rsthold_pre", h0, m0, s0, 0, 1, 0, 2'd2, 1'b1);
        m0 = pulses[1];
        apply_reset();
        run_ticks(3'b010, 2);
        expect_seg("rsthold_in", h0, m0, s0, 0, 0, 0, 2'd0, 1'b0);
        rst_n = 1'b1;
        run_ticks(3'b010, 3);
        expect_seg("rsthold_t25", h0, m0, s0, 0, 0, 0, 2'd0, 1'b0);
        run_ticks(3'b010, 1);
        expect_seg("rsthold_t26", h0, m0, s0, 0, 1, 0, 2'd2, 1'b1);
        m0 = pulses[1];
        run_ticks(3'b010, 29);
        expect_seg("rsthold_t55", h0, m0, s0, 0, 0, 0, 2'd2, 1'b1);
        run_ticks(3'b010, 1);
        expect_seg("rsthold_t56", h0, m0, s0, 0, 1, 0, 2'd2, 1'b1);
        m0 = pulses[1];
        run_ticks(3'b000, 5);
        expect_seg("rsthold_idle", h0, m0, s0, 0, 0, 0, 2'd0, 1'b0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(0, 119) == 0) btn = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2999) == 0) begin
                apply_reset();
                cycle(1'b0);
                rst_n = 1'b1;
            end
            cycle($urandom_range(0, 2) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
